// File: rtl/vector_writeback_regfile.sv
// Vector register file with a same-cycle writeback bypass and a 2-bit pending-write scoreboard.
// Reads and hazard are combinational; writes and scoreboard updates take effect on the next clk edge.
module vector_writeback_regfile #(
    parameter int N     = 20,
    parameter int LANES = 8,
    parameter int REGS  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [LANES-1:0][N-1:0]   RDM,
    input  logic [LANES-1:0][N-1:0]   ALUOutM,
    input  logic                      RegWriteM,
    input  logic                      MemtoRegM,
    input  logic [3:0]                WA3M,
    input  logic [3:0]                RA1,
    input  logic [3:0]                RA2,
    input  logic                      issue_valid,
    input  logic                      issue_regwrite,
    input  logic [3:0]                issue_wa,
    output logic [LANES-1:0][N-1:0]   RD1,
    output logic [LANES-1:0][N-1:0]   RD2,
    output logic [LANES-1:0][N-1:0]   ResultW,
    output logic                      hazard,
    output logic                      issue_ready
);

    logic [LANES-1:0][N-1:0] regs [REGS];
    logic [1:0]              cnt  [REGS];

    logic            wb_en;
    logic            inc_en;
    logic            dec1;
    logic            dec2;
    logic [REGS-1:0] inc_vec;
    logic [REGS-1:0] dec_vec;

    assign ResultW = MemtoRegM ? RDM : ALUOutM;
    assign wb_en   = RegWriteM && (WA3M != 4'd0);

    always_comb begin
        RD1 = '0;
        if (RA1 != 4'd0)
            RD1 = (wb_en && WA3M == RA1) ? ResultW : regs[RA1];
    end

    always_comb begin
        RD2 = '0;
        if (RA2 != 4'd0)
            RD2 = (wb_en && WA3M == RA2) ? ResultW : regs[RA2];
    end

    // A writeback in flight retires one pending write for hazard purposes.
    assign dec1   = wb_en && (WA3M == RA1);
    assign dec2   = wb_en && (WA3M == RA2);
    assign hazard = ((RA1 != 4'd0) && (cnt[RA1] > {1'b0, dec1})) ||
                    ((RA2 != 4'd0) && (cnt[RA2] > {1'b0, dec2}));

    assign issue_ready = !((cnt[issue_wa] == 2'd3) && !(wb_en && WA3M == issue_wa));
    assign inc_en      = issue_valid && issue_regwrite && (issue_wa != 4'd0) && issue_ready;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (inc_en)
            inc_vec[issue_wa] = 1'b1;
        if (wb_en)
            dec_vec[WA3M] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REGS; i++) begin
                regs[i] <= '0;
                cnt[i]  <= 2'd0;
            end
        end else begin
            if (wb_en)
                regs[WA3M] <= ResultW;
            for (int i = 0; i < REGS; i++) begin
                case ({inc_vec[i], dec_vec[i]})
                    2'b10:   cnt[i] <= cnt[i] + 2'd1;
                    2'b01:   if (cnt[i] != 2'd0) cnt[i] <= cnt[i] - 2'd1;
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vector_writeback_regfile.sv
// Directed bench for vector_writeback_regfile: a per-cycle reference model plus hand-computed literal checks.
module tb_vector_writeback_regfile;

    localparam int W = 160;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0][19:0]  rdm, aluout;
    logic              regwrite, memtoreg;
    logic [3:0]        wa3, ra1, ra2;
    logic              issue_valid, issue_regwrite;
    logic [3:0]        issue_wa;
    logic [7:0][19:0]  rd1, rd2, result;
    logic              hazard, issue_ready;

    vector_writeback_regfile dut (
        .clk(clk), .reset(reset), .RDM(rdm), .ALUOutM(aluout),
        .RegWriteM(regwrite), .MemtoRegM(memtoreg), .WA3M(wa3),
        .RA1(ra1), .RA2(ra2), .issue_valid(issue_valid),
        .issue_regwrite(issue_regwrite), .issue_wa(issue_wa),
        .RD1(rd1), .RD2(rd2), .ResultW(result),
        .hazard(hazard), .issue_ready(issue_ready)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit chk_en = 0;

    // Reference state: register contents and number of outstanding writes per register.
    logic [W-1:0] m_regs [16];
    int           m_cnt  [16];

    logic [W-1:0] pat_a, pat_b, pat_alu, pat_ones;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        else
            passed++;
    endtask

    function automatic logic [W-1:0] exp_res();
        return memtoreg ? W'(rdm) : W'(aluout);
    endfunction

    function automatic bit wb_hits(input logic [3:0] r);
        return regwrite && wa3 != 0 && wa3 == r;
    endfunction

    function automatic logic [W-1:0] exp_rd(input logic [3:0] ra);
        if (ra == 0) return '0;
        if (wb_hits(ra)) return exp_res();
        return m_regs[ra];
    endfunction

    function automatic bit busy(input logic [3:0] ra);
        int eff;
        if (ra == 0) return 0;
        eff = m_cnt[ra] - (wb_hits(ra) ? 1 : 0);
        return eff > 0;
    endfunction

    function automatic bit exp_ready();
        return !(m_cnt[issue_wa] >= 3 && !wb_hits(issue_wa));
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = '0;
            m_cnt[i]  = 0;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_regs[i] = '0;
                m_cnt[i]  = 0;
            end
        end else begin
            bit rdy;
            rdy = exp_ready();
            // Increment before decrement so a matched pair nets to no change, even from zero.
            if (issue_valid && issue_regwrite && issue_wa != 0 && rdy)
                m_cnt[issue_wa]++;
            if (regwrite && wa3 != 0) begin
                m_regs[wa3] = exp_res();
                if (m_cnt[wa3] > 0) m_cnt[wa3]--;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_result", result, exp_res());
            check("model_rd1", rd1, exp_rd(ra1));
            check("model_rd2", rd2, exp_rd(ra2));
            check("model_hazard", W'(hazard), W'(busy(ra1) || busy(ra2)));
            check("model_ready", W'(issue_ready), W'(exp_ready()));
        end
    end

    task automatic idle();
        rdm = '0; aluout = '0; regwrite = 0; memtoreg = 0; wa3 = 0;
        ra1 = 0; ra2 = 0; issue_valid = 0; issue_regwrite = 0; issue_wa = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] wa);
        issue_valid = 1; issue_regwrite = 1; issue_wa = wa;
    endtask

    task automatic wb_alu(input logic [3:0] wa, input logic [W-1:0] v);
        regwrite = 1; memtoreg = 0; wa3 = wa; aluout = v;
    endtask

    initial begin
        pat_a    = {8{20'h12345}};
        pat_b    = {8{20'hABCDE}};
        pat_ones = {8{20'hFFFFF}};
        pat_alu  = {20'h00008, 20'h00007, 20'h00006, 20'h00005,
                    20'h00004, 20'h00003, 20'h00002, 20'h00001};
        idle();
        reset = 1;

        // Reset state
        issue(4'd6); wb_alu(4'd6, pat_ones);
        step();
        chk_en = 1;
        idle(); ra1 = 5; ra2 = 0;
        @(negedge clk);
        check("rst_rd1", rd1, '0);
        check("rst_rd2", rd2, '0);
        check("rst_hazard", W'(hazard), '0);
        check("rst_ready", W'(issue_ready), W'(1'b1));
        step();
        reset = 0;
        ra1 = 6;
        @(negedge clk);
        check("rst_discard_rd1", rd1, '0);
        check("rst_discard_hazard", W'(hazard), '0);
        step();

        // Memory-select writeback with same-cycle bypass
        idle(); regwrite = 1; memtoreg = 1; wa3 = 3; rdm = pat_a; aluout = pat_b; ra1 = 3;
        @(negedge clk);
        check("mem_bypass_rd1", rd1, pat_a);
        check("mem_resultw", result, pat_a);
        step();
        idle(); ra1 = 3;
        @(negedge clk);
        check("mem_array_rd1", rd1, pat_a);
        check("mem_no_underflow_hazard", W'(hazard), '0);
        step();

        // Issue to 4: hazard only from the next cycle, cleared by its writeback
        idle(); issue(4'd4); ra1 = 4;
        @(negedge clk);
        check("issue_same_cycle_hazard", W'(hazard), '0);
        step();
        idle(); ra2 = 4;
        @(negedge clk);
        check("pending4_hazard", W'(hazard), W'(1'b1));
        step();
        idle(); ra1 = 4; wb_alu(4'd4, pat_alu);
        @(negedge clk);
        check("wb4_hazard", W'(hazard), '0);
        check("wb4_rd1", rd1, pat_alu);
        step();
        idle(); ra1 = 4;
        @(negedge clk);
        check("after_wb4_rd1", rd1, pat_alu);
        step();

        // Saturating scoreboard on register 7
        for (int k = 0; k < 3; k++) begin
            idle(); issue(4'd7);
            step();
        end
        idle(); issue(4'd7); ra1 = 7;
        @(negedge clk);
        check("full7_ready", W'(issue_ready), '0);
        check("model_cnt7_full", W'(m_cnt[7]), W'(3));
        step();
        idle(); ra1 = 7; issue_wa = 7; wb_alu(4'd7, pat_b);
        @(negedge clk);
        check("full7_ready_with_wb", W'(issue_ready), W'(1'b1));
        check("wb7_first_hazard", W'(hazard), W'(1'b1));
        step();
        idle(); ra1 = 7; wb_alu(4'd7, pat_b);
        @(negedge clk);
        check("wb7_second_hazard", W'(hazard), W'(1'b1));
        step();
        idle(); ra1 = 7; wb_alu(4'd7, pat_b);
        @(negedge clk);
        check("wb7_third_hazard", W'(hazard), '0);
        step();
        idle(); ra1 = 7;
        @(negedge clk);
        check("drained7_hazard", W'(hazard), '0);
        check("model_cnt7_empty", W'(m_cnt[7]), '0);
        step();

        // Simultaneous issue and writeback on register 2
        idle(); issue(4'd2);
        step();
        idle(); issue(4'd2); wb_alu(4'd2, pat_alu); ra2 = 2;
        @(negedge clk);
        check("simul2_hazard_now", W'(hazard), '0);
        step();
        idle(); ra2 = 2;
        @(negedge clk);
        check("simul2_hazard_next", W'(hazard), W'(1'b1));
        check("model_cnt2", W'(m_cnt[2]), W'(1));
        step();
        idle(); wb_alu(4'd2, pat_a);
        step();

        // Writes to register 0 are ignored
        idle(); wb_alu(4'd0, pat_ones); ra1 = 0;
        @(negedge clk);
        check("r0_bypass_rd1", rd1, '0);
        check("r0_resultw", result, pat_ones);
        step();
        idle(); ra1 = 0; issue_wa = 0;
        @(negedge clk);
        check("r0_rd1", rd1, '0);
        check("r0_hazard", W'(hazard), '0);
        check("r0_ready", W'(issue_ready), W'(1'b1));
        step();

        // Mid-operation reset discards pending writes and data
        idle(); issue(4'd9);
        step();
        idle(); ra1 = 9;
        @(negedge clk);
        check("pending9_hazard", W'(hazard), W'(1'b1));
        step();
        idle(); reset = 1; wb_alu(4'd5, pat_ones);
        step();
        idle(); reset = 0; ra1 = 9; ra2 = 3;
        @(negedge clk);
        check("post_rst_hazard9", W'(hazard), '0);
        check("post_rst_rd2", rd2, '0);
        step();
        idle(); ra1 = 5;
        @(negedge clk);
        check("post_rst_rd1_r5", rd1, '0);
        step();

        chk_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
